imsic_msi_arbiter: RTL and testbench

Shares the single MSI delivery channel (`i_msi_info` / `i_msi_info_vld`) of the IMSIC interrupt-file gates among several MSI sources, such as bus write ports and the internal self-IPI path. It arbitrates round-robin, optionally queues accepted messages, and sequences each one as a level pulse. `msi_info` is held stable long enough for every gate's valid synchronizer and falling-edge capture to complete. It sits between the MSI write decoders and the per-hart `imsic_csr_gate` instances, which all receive the same broadcast.

---
 rtl/imsic_msi_arbiter_if.sv | 27 ++
 rtl/imsic_msi_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_imsic_msi_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imsic_msi_arbiter_if.sv
// ---------------------------------------------------------------------------
// imsic_msi_arbiter_if
//
// Purpose: request-side handshake bundle between the MSI sources (bus write
// decoders, self-IPI path) and imsic_msi_arbiter.
//
// Signals:
//   req_vld   NR_REQ                  per-requester message valid
//   req_info  NR_REQ*MSI_INFO_WIDTH   per-requester message, requester i at
//                                     bits [i*MSI_INFO_WIDTH +: MSI_INFO_WIDTH]
//   req_rdy   NR_REQ                  per-requester accept (one-hot or zero)
//
// Modports:
//   master  the requesters (drive valid/info, observe ready)
//   slave   the arbiter    (observe valid/info, drive ready)
// ---------------------------------------------------------------------------
interface imsic_msi_arbiter_if #(
   parameter int NR_REQ         = 2,
   parameter int MSI_INFO_WIDTH = 17
);
   logic [NR_REQ-1:0]                req_vld;
   logic [NR_REQ*MSI_INFO_WIDTH-1:0] req_info;
   logic [NR_REQ-1:0]                req_rdy;

   modport master (output req_vld, output req_info, input  req_rdy);
   modport slave  (input  req_vld, input  req_info, output req_rdy);
endinterface

// File: rtl/imsic_msi_arbiter.sv
// ---------------------------------------------------------------------------
// imsic_msi_arbiter
//
// Purpose: shares the single MSI broadcast channel feeding the per-hart
// imsic_csr_gate instances among several MSI sources. Requests are granted
// round-robin; each accepted message is sent as a valid pulse VLD_HIGH cycles
// wide, after which the message is held for a further VLD_LOW cycles so every
// gate's valid synchronizer and falling-edge capture can finish.
//
// Optional feature: define IMSIC_MSI_ARB_FIFO_EN to place a FIFO_DEPTH-entry
// queue between the arbiter and the sender, so requesters can be accepted
// while a pulse is in flight. Without it, messages are accepted only while
// the sender is idle and load straight into o_msi_info.
//
// Ports:
//   clk             in   clock
//   rstn            in   asynchronous active-low reset
//   req_if          slave request bundle (req_vld / req_info / req_rdy)
//   o_msi_info      out  broadcast message {hart_id, intp_file, setipnum}
//   o_msi_info_vld  out  broadcast valid pulse
//   busy            out  sender active or queue non-empty
// ---------------------------------------------------------------------------
module imsic_msi_arbiter #(
   parameter int NR_REQ         = 2,
   parameter int MSI_INFO_WIDTH = 17,
   parameter int VLD_HIGH       = 4,
   parameter int VLD_LOW        = 8,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                      clk,
   input  logic                      rstn,
   imsic_msi_arbiter_if.slave        req_if,
   output logic [MSI_INFO_WIDTH-1:0] o_msi_info,
   output logic                      o_msi_info_vld,
   output logic                      busy
);

   localparam int W       = MSI_INFO_WIDTH;
   localparam int MAX_CNT = (VLD_HIGH > VLD_LOW) ? VLD_HIGH : VLD_LOW;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);
   localparam int PTR_W   = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

   // Elaboration-time sanity check of the configuration.
   if (NR_REQ < 1 || NR_REQ > 8 || VLD_HIGH < 1 || VLD_LOW < 1 ||
       FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
      $error("imsic_msi_arbiter: illegal parameter combination");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               r_vld;
   logic [W-1:0]       r_info;

   logic [PTR_W-1:0]   r_rr_ptr;
   logic [PTR_W-1:0]   w_gnt_idx;
   logic               w_gnt_found;
   logic [NR_REQ-1:0]  w_grant;
   logic               w_sink_ready;
   logic               w_xfer;
   logic [W-1:0]       w_xfer_info;
   logic               w_load;
   logic [W-1:0]       w_load_info;

   // Round-robin search: the first valid requester after rr_ptr wins, so the
   // requester that was served last has the lowest priority next time.
   always_comb begin
      w_gnt_found = 1'b0;
      w_gnt_idx   = r_rr_ptr;
      w_grant     = '0;
      for (int k = 1; k <= NR_REQ; k++) begin
         if (!w_gnt_found && req_if.req_vld[(int'(r_rr_ptr) + k) % NR_REQ]) begin
            w_gnt_found = 1'b1;
            w_gnt_idx   = PTR_W'((int'(r_rr_ptr) + k) % NR_REQ);
         end
      end
      if (w_gnt_found) begin
         w_grant[w_gnt_idx] = 1'b1;
      end
   end

   // The grant is only offered when the sink can take it; w_sink_ready also
   // folds in rstn so nothing is acknowledged while reset is held.
   assign req_if.req_rdy = w_grant & {NR_REQ{w_sink_ready}};
   assign w_xfer         = w_gnt_found & w_sink_ready;
   assign w_xfer_info    = req_if.req_info[int'(w_gnt_idx)*W +: W];

   // Priority pointer moves to the requester just served.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rr_ptr <= PTR_W'(NR_REQ - 1);
      end else if (w_xfer) begin
         r_rr_ptr <= w_gnt_idx;
      end
   end

`ifdef IMSIC_MSI_ARB_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [W-1:0]  r_fifo [FIFO_DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   logic          w_full;
   logic          w_empty;
   logic          w_pop;

   // Full is judged on the occupancy at the start of the cycle, so a pop in
   // the same cycle does not open the door for a push.
   assign w_full       = (r_count == (AW+1)'(FIFO_DEPTH));
   assign w_empty      = (r_count == '0);
   assign w_pop        = (r_state == IDLE) && !w_empty;
   assign w_sink_ready = rstn & ~w_full;
   assign w_load       = w_pop;
   assign w_load_info  = r_fifo[r_rptr];
   assign busy         = (r_state != IDLE) | ~w_empty;

   // Queue storage carries no reset; only pointers and occupancy do.
   always_ff @(posedge clk) begin
      if (w_xfer) begin
         r_fifo[r_wptr] <= w_xfer_info;
      end
   end

   // Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_xfer) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_xfer, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
`else
   // Without a queue the arbiter can only hand a message over while the
   // sender is idle, and that message goes straight onto the broadcast bus.
   assign w_sink_ready = rstn & (r_state == IDLE);
   assign w_load       = w_xfer;
   assign w_load_info  = w_xfer_info;
   assign busy         = (r_state != IDLE);
`endif

   // Sender next-state: IDLE -> HIGH on a load, HIGH holds the valid for
   // VLD_HIGH cycles, LOW keeps the message stable for VLD_LOW more cycles.
   // The counter is reloaded on every transition and never wraps.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_load) begin
               w_state_nxt = HIGH;
               w_cnt_nxt   = CNT_W'(VLD_HIGH - 1);
            end
         end
         HIGH: begin
            if (r_cnt == '0) begin
               w_state_nxt = LOW;
               w_cnt_nxt   = CNT_W'(VLD_LOW - 1);
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         LOW: begin
            if (r_cnt == '0) begin
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Sender registers; the valid is registered so the gates see a clean
   // level, and the message only changes when a new one is loaded.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_vld   <= 1'b0;
         r_info  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_vld   <= (w_state_nxt == HIGH);
         if (w_load) begin
            r_info <= w_load_info;
         end
      end
   end

   assign o_msi_info     = r_info;
   assign o_msi_info_vld = r_vld;

endmodule

// File: tb/tb_imsic_msi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imsic_msi_arbiter
//
// Purpose: self-checking bench for imsic_msi_arbiter (NR_REQ=2, 17-bit info,
// VLD_HIGH=4, VLD_LOW=8, FIFO_DEPTH=4). Follows IMSIC_MSI_ARB_FIFO_EN the same
// way the design does. A cycle-level model predicts req_rdy, o_msi_info,
// o_msi_info_vld and busy every cycle from pulse start/end cycle numbers and a
// message queue; directed scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_imsic_msi_arbiter;

   localparam int NR    = 2;
   localparam int W     = 17;
   localparam int VH    = 4;
   localparam int VL    = 8;
   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         rstn;
   logic [W-1:0] msiInfo;
   logic         msiVld;
   logic         busy;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   imsic_msi_arbiter_if #(.NR_REQ(NR), .MSI_INFO_WIDTH(W)) reqIf ();

   imsic_msi_arbiter #(
      .NR_REQ        (NR),
      .MSI_INFO_WIDTH(W),
      .VLD_HIGH      (VH),
      .VLD_LOW       (VL),
      .FIFO_DEPTH    (DEPTH)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .req_if        (reqIf.slave),
      .o_msi_info    (msiInfo),
      .o_msi_info_vld(msiVld),
      .busy          (busy)
   );

   // Free-running clock and a cycle number that changes only at posedge.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model state: pulse window as cycle numbers, held message, queue, pointer.
   int           mRr;
   int           mVldFrom;
   int           mVldUntil;
   int           mBusyUntil;
   logic [W-1:0] mInfo;
   logic [W-1:0] mQ[$];
   int           mGnt;
   bit           mSinkReady;
   bit           mSenderIdle;
   logic [NR-1:0] mExpRdy;

   // Compare process: checks the DUT against the model in every cycle, then
   // advances the model with what the coming posedge must do.
   always @(negedge clk) begin
      if (!rstn) begin
         mRr        = NR - 1;
         mVldFrom   = 0;
         mVldUntil  = 0;
         mBusyUntil = 0;
         mInfo      = '0;
         mQ.delete();
         checkOutput("rstRdy",  32'(reqIf.req_rdy), 32'd0);
         checkOutput("rstVld",  32'(msiVld),        32'd0);
         checkOutput("rstInfo", 32'(msiInfo),       32'd0);
         checkOutput("rstBusy", 32'(busy),          32'd0);
      end else begin
         mSenderIdle = !(cyc >= mVldFrom && cyc < mBusyUntil);
`ifdef IMSIC_MSI_ARB_FIFO_EN
         mSinkReady = (mQ.size() < DEPTH);
`else
         mSinkReady = mSenderIdle;
`endif
         mGnt = -1;
         for (int k = 1; k <= NR; k++) begin
            if (mGnt < 0 && reqIf.req_vld[(mRr + k) % NR]) mGnt = (mRr + k) % NR;
         end
         mExpRdy = '0;
         if (mGnt >= 0 && mSinkReady) mExpRdy[mGnt] = 1'b1;

         checkOutput("rdy",  32'(reqIf.req_rdy), 32'(mExpRdy));
         checkOutput("vld",  32'(msiVld),  32'(cyc >= mVldFrom && cyc < mVldUntil));
         checkOutput("info", 32'(msiInfo), 32'(mInfo));
         checkOutput("busy", 32'(busy),    32'(!mSenderIdle || mQ.size() != 0));

`ifdef IMSIC_MSI_ARB_FIFO_EN
         if (mSenderIdle && mQ.size() != 0) begin
            mInfo      = mQ.pop_front();
            mVldFrom   = cyc + 1;
            mVldUntil  = cyc + 1 + VH;
            mBusyUntil = cyc + 1 + VH + VL;
         end
`endif
         if (mGnt >= 0 && mSinkReady) begin
            mRr = mGnt;
`ifdef IMSIC_MSI_ARB_FIFO_EN
            mQ.push_back(reqIf.req_info[mGnt*W +: W]);
`else
            mInfo      = reqIf.req_info[mGnt*W +: W];
            mVldFrom   = cyc + 1;
            mVldUntil  = cyc + 1 + VH;
            mBusyUntil = cyc + 1 + VH + VL;
`endif
         end
      end
   end

   // Records each message at the cycle its valid pulse starts.
   logic [W-1:0] delivered[$];
   logic         prevVld = 1'b0;
   always @(negedge clk) begin
      if (rstn && msiVld && !prevVld) delivered.push_back(msiInfo);
      prevVld = msiVld;
   end

   task automatic applyStimulus(input logic [NR-1:0] vld, input logic [W-1:0] info0, input logic [W-1:0] info1);
      reqIf.req_vld  = vld;
      reqIf.req_info = {info1, info0};
   endtask

   // Waits for requester idx to be accepted; returns the accept cycle and
   // leaves the caller just after the accepting posedge.
   task automatic waitRdy(input int idx, output int acceptCyc);
      int n = 0;
      acceptCyc = -1;
      forever begin
         @(negedge clk);
         if (reqIf.req_rdy[idx]) break;
         n++;
         if (n > 200) begin
            checkOutput("timeoutRdy", 32'd1, 32'd0);
            return;
         end
      end
      acceptCyc = cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic waitAnyRdy(output int idx, output int acceptCyc);
      int n = 0;
      idx = -1;
      acceptCyc = -1;
      forever begin
         @(negedge clk);
         if (reqIf.req_rdy != '0) break;
         n++;
         if (n > 200) begin
            checkOutput("timeoutAnyRdy", 32'd1, 32'd0);
            return;
         end
      end
      idx = reqIf.req_rdy[0] ? 0 : 1;
      acceptCyc = cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic waitIdle();
      int n = 0;
      forever begin
         @(negedge clk);
         if (!busy && !msiVld) break;
         n++;
         if (n > 400) begin
            checkOutput("timeoutIdle", 32'd1, 32'd0);
            return;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      @(posedge clk);
      #1 rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      delivered.delete();
   endtask

   int t, idx, hi, bad, firstHi, n;
   int order[4];
   int acc[6];

   initial begin
      rstn = 1'b1;
      applyStimulus(2'b11, 17'h1FFFF, 17'h1FFFF);
      #1 rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      applyStimulus(2'b00, '0, '0);
      repeat (2) @(posedge clk);
      #1;

`ifndef IMSIC_MSI_ARB_FIFO_EN
      // Single request from requester 0: 4 high, message held 12 cycles.
      $display("[TB] single request, direct path");
      applyStimulus(2'b01, 17'h00005, '0);
      waitRdy(0, t);
      applyStimulus(2'b00, '0, '0);
      hi = 0; bad = 0; firstHi = -1;
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         if (k <= 12) begin
            if (msiVld) begin
               hi++;
               if (firstHi < 0) firstHi = k;
            end
            if (msiInfo !== 17'h00005) bad++;
         end else begin
            checkOutput("t1BusyEnd", 32'(busy),   32'd0);
            checkOutput("t1VldEnd",  32'(msiVld), 32'd0);
         end
      end
      checkOutput("t1HighCycles", 32'(hi),      32'd4);
      checkOutput("t1FirstHigh",  32'(firstHi), 32'd1);
      checkOutput("t1InfoHeld",   32'(bad),     32'd0);
      @(posedge clk);
      #1;
`endif

      // Both requesters held valid: grants alternate starting with 0.
      $display("[TB] two requesters contending");
      doReset();
      applyStimulus(2'b11, 17'h10003, 17'h00007);
      for (int k = 0; k < 4; k++) begin
         waitAnyRdy(idx, acc[k]);
         order[k] = idx;
      end
      applyStimulus(2'b00, '0, '0);
      for (int k = 0; k < 4; k++) checkOutput("t2Order", 32'(order[k]), 32'(k % 2));
`ifdef IMSIC_MSI_ARB_FIFO_EN
      for (int k = 1; k < 4; k++) checkOutput("t2Gap", 32'(acc[k] - acc[k-1]), 32'd1);
`else
      for (int k = 1; k < 4; k++) checkOutput("t2Gap", 32'(acc[k] - acc[k-1]), 32'd13);
`endif
      waitIdle();
      checkOutput("t2NumDelivered", 32'(delivered.size()), 32'd4);
      for (int k = 0; k < 4 && k < delivered.size(); k++)
         checkOutput("t2Delivered", 32'(delivered[k]), (k % 2 == 0) ? 32'h10003 : 32'h00007);

`ifdef IMSIC_MSI_ARB_FIFO_EN
      // Write into an idle, empty queue: valid rises two cycles later.
      $display("[TB] fifo latency");
      applyStimulus(2'b01, 17'h00042, '0);
      waitRdy(0, t);
      applyStimulus(2'b00, '0, '0);
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         if (msiVld) break;
         n++;
      end
      checkOutput("t5Latency", 32'(cyc - t), 32'd2);
      waitIdle();

      // Six back-to-back from requester 0: queue fills, then one per pulse.
      $display("[TB] fifo back-to-back");
      delivered.delete();
      for (int k = 0; k < 6; k++) begin
         applyStimulus(2'b01, W'(k + 1), '0);
         waitRdy(0, acc[k]);
      end
      applyStimulus(2'b00, '0, '0);
      checkOutput("t4SecondGap", 32'(acc[1] - acc[0]), 32'd1);
      checkOutput("t4FifthGap",  32'(acc[4] - acc[0]), 32'd4);
      checkOutput("t4SixthGap",  32'(acc[5] - acc[0]), 32'd15);
      waitIdle();
      checkOutput("t4NumDelivered", 32'(delivered.size()), 32'd6);
      for (int k = 0; k < 6 && k < delivered.size(); k++)
         checkOutput("t4Delivered", 32'(delivered[k]), 32'(k + 1));
`endif

      // Reset while a pulse is high (with two queued in the FIFO build).
      $display("[TB] reset mid-message");
      doReset();
      applyStimulus(2'b01, 17'h0AAAA, '0);
      waitRdy(0, t);
`ifdef IMSIC_MSI_ARB_FIFO_EN
      applyStimulus(2'b01, 17'h0BBBB, '0);
      waitRdy(0, t);
      applyStimulus(2'b01, 17'h0CCCC, '0);
      waitRdy(0, t);
`endif
      applyStimulus(2'b00, '0, '0);
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         if (msiVld) break;
         n++;
      end
      @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      checkOutput("t3RstVld",  32'(msiVld),  32'd0);
      checkOutput("t3RstInfo", 32'(msiInfo), 32'd0);
      checkOutput("t3RstBusy", 32'(busy),    32'd0);
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      hi = 0;
      repeat (25) begin
         @(negedge clk);
         if (msiVld) hi++;
      end
      checkOutput("t3NoPulseAfterRst", 32'(hi), 32'd0);
      @(posedge clk);
      #1;
      applyStimulus(2'b11, 17'h00011, 17'h00022);
      waitAnyRdy(idx, t);
      applyStimulus(2'b00, '0, '0);
      checkOutput("t3FirstGrant", 32'(idx), 32'd0);
      waitIdle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Overall time bound in case a wait escapes its own budget.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
